// File: rtl/soc_mem_copy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_mem_copy_pkg
// Description : Shared constants and types for the memory copy DMA: CSR word
//               offsets, CTRL/STATUS bit positions, address/count widths and
//               the copy FSM state type.
// Revision    : 1.0  initial release
// ============================================================================
package soc_mem_copy_pkg;

    localparam int ADDR_W = 13;
    localparam int CNT_W  = ADDR_W + 1;

    // CSR word offsets
    localparam logic [1:0] CSR_SRC  = 2'd0;
    localparam logic [1:0] CSR_DST  = 2'd1;
    localparam logic [1:0] CSR_LEN  = 2'd2;
    localparam logic [1:0] CSR_CTRL = 2'd3;

    // CTRL write bits
    localparam int CTRL_GO  = 0;
    localparam int CTRL_IE  = 1;
    localparam int CTRL_CLR = 2;

    // STATUS read bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_IE   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/soc_mem_copy_csr.sv
`default_nettype none
// ============================================================================
// Module      : soc_mem_copy_csr
// Description : CSR register file of the memory copy DMA. Holds SRC/DST/LEN,
//               the done/error/ie flags, validates a go request and produces
//               the registered readback (latency 1) and the level interrupt.
// Ports       : clk, reset_n          clock, async active-low reset
//               i_address/i_read/i_write/i_writedata  Avalon-MM CSR slave
//               o_readdata            registered read data
//               i_busy                copy FSM is active
//               i_word_done           one word written (LEN decrements)
//               i_xfer_done           last word written (sets done)
//               o_src/o_dst/o_len     programmed values for the FSM
//               o_start               validated go, FSM loads pointers
//               o_irq                 done & ie
// Revision    : 1.0  initial release
// ============================================================================
module soc_mem_copy_csr #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          i_address,
    input  logic                i_read,
    input  logic                i_write,
    input  logic [31:0]         i_writedata,
    output logic [31:0]         o_readdata,
    input  logic                i_busy,
    input  logic                i_word_done,
    input  logic                i_xfer_done,
    output logic [ADDR_W-1:0]   o_src,
    output logic [ADDR_W-1:0]   o_dst,
    output logic [ADDR_W:0]     o_len,
    output logic                o_start,
    output logic                o_irq
);
    import soc_mem_copy_pkg::*;

    localparam int               C_CNT_W = ADDR_W + 1;
    localparam logic [C_CNT_W:0] C_DEPTH = (C_CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [C_CNT_W-1:0] r_len;
    logic               r_done;
    logic               r_err;
    logic               r_ie;
    logic [31:0]        r_readdata;

    logic               w_ctrl_wr;
    logic               w_go;
    logic               w_clr;
    logic               w_len_zero;
    logic               w_range_err;
    logic [C_CNT_W:0]   w_src_end;
    logic [C_CNT_W:0]   w_dst_end;
    logic [31:0]        w_rd_mux;
    logic               w_unused_wdata;

    assign w_ctrl_wr  = i_write && (i_address == CSR_CTRL);
    // A go while busy is dropped entirely; ie/clear still apply.
    assign w_go       = w_ctrl_wr && i_writedata[CTRL_GO] && !i_busy;
    assign w_clr      = w_ctrl_wr && i_writedata[CTRL_CLR];
    assign w_len_zero = (r_len == '0);

    // One extra bit of headroom so an oversized LEN cannot wrap the sum.
    assign w_src_end   = {2'b00, r_src} + {1'b0, r_len};
    assign w_dst_end   = {2'b00, r_dst} + {1'b0, r_len};
    assign w_range_err = (w_src_end > C_DEPTH) || (w_dst_end > C_DEPTH);

    assign o_start    = w_go && !w_len_zero && !w_range_err;
    assign o_src      = r_src;
    assign o_dst      = r_dst;
    assign o_len      = r_len;
    assign o_irq      = r_done && r_ie;
    assign o_readdata = r_readdata;

    assign w_unused_wdata = &{1'b0, i_writedata[31:C_CNT_W]};

    always_comb begin
        w_rd_mux = '0;
        case (i_address)
            CSR_SRC:  w_rd_mux[ADDR_W-1:0]  = r_src;
            CSR_DST:  w_rd_mux[ADDR_W-1:0]  = r_dst;
            CSR_LEN:  w_rd_mux[C_CNT_W-1:0] = r_len;
            CSR_CTRL: begin
                w_rd_mux[STAT_BUSY] = i_busy;
                w_rd_mux[STAT_DONE] = r_done;
                w_rd_mux[STAT_ERR]  = r_err;
                w_rd_mux[STAT_IE]   = r_ie;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ie       <= 1'b0;
            r_readdata <= '0;
        end else begin
            // Register writes only land in IDLE; LEN becomes the live
            // remaining count while the copy runs.
            if (i_write && !i_busy) begin
                case (i_address)
                    CSR_SRC: r_src <= i_writedata[ADDR_W-1:0];
                    CSR_DST: r_dst <= i_writedata[ADDR_W-1:0];
                    CSR_LEN: r_len <= i_writedata[C_CNT_W-1:0];
                    default: ;
                endcase
            end else if (i_word_done) begin
                r_len <= r_len - 1'b1;
            end

            if (w_ctrl_wr) begin
                r_ie <= i_writedata[CTRL_IE];
            end

            // Go outranks clear: it resets the flags itself and then
            // reports the immediate outcome (empty or out of range).
            if (w_go) begin
                r_done <= w_len_zero || w_range_err;
                r_err  <= !w_len_zero && w_range_err;
            end else if (i_xfer_done) begin
                r_done <= 1'b1;
            end else if (w_clr) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end

            r_readdata <= i_read ? w_rd_mux : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/soc_mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : soc_mem_copy_dma
// Description : Word-granular copy engine driving the second port of the
//               on-chip data memory. Each word takes three cycles:
//               RD (present source address), CAP (capture read data),
//               WR (write to destination, advance pointers).
// Ports       : clk, reset_n          clock, async active-low reset
//               csr_*                 Avalon-MM CSR slave (4 words)
//               irq                   level interrupt (done & ie)
//               mem_*                 data memory master port
// Revision    : 1.0  initial release
// ============================================================================
module soc_mem_copy_dma #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          csr_address,
    input  logic                csr_read,
    input  logic                csr_write,
    input  logic [31:0]         csr_writedata,
    output logic [31:0]         csr_readdata,
    output logic                irq,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [3:0]          mem_byteenable,
    output logic [31:0]         mem_writedata,
    input  logic [31:0]         mem_readdata
);
    import soc_mem_copy_pkg::*;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_src_ptr;
    logic [ADDR_W-1:0]  r_dst_ptr;
    logic [31:0]        r_data;

    logic               w_busy;
    logic               w_start;
    logic               w_word_done;
    logic               w_last;
    logic               w_xfer_done;
    logic [ADDR_W-1:0]  w_src;
    logic [ADDR_W-1:0]  w_dst;
    logic [ADDR_W:0]    w_len;

    assign w_busy      = (r_state != IDLE);
    assign w_word_done = (r_state == WR);
    // LEN counts down in the CSR block; the word written with LEN==1 is last.
    assign w_last      = (w_len == (ADDR_W + 1)'(1));
    assign w_xfer_done = w_word_done && w_last;

    assign mem_byteenable = 4'hF;
    assign mem_writedata  = r_data;

    soc_mem_copy_csr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_csr (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_address   (csr_address),
        .i_read      (csr_read),
        .i_write     (csr_write),
        .i_writedata (csr_writedata),
        .o_readdata  (csr_readdata),
        .i_busy      (w_busy),
        .i_word_done (w_word_done),
        .i_xfer_done (w_xfer_done),
        .o_src       (w_src),
        .o_dst       (w_dst),
        .o_len       (w_len),
        .o_start     (w_start),
        .o_irq       (irq)
    );

    // Memory strobes decode straight from the state register so reset
    // removes them asynchronously.
    always_comb begin
        w_next         = r_state;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = RD;
                end
            end
            RD: begin
                mem_chipselect = 1'b1;
                mem_address    = r_src_ptr;
                w_next         = CAP;
            end
            CAP: begin
                w_next = WR;
            end
            WR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = r_dst_ptr;
                w_next         = w_last ? IDLE : RD;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_data    <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_src_ptr <= w_src;
                r_dst_ptr <= w_dst;
            end
            if (r_state == CAP) begin
                r_data <= mem_readdata;
            end
            if (r_state == WR) begin
                r_src_ptr <= r_src_ptr + 1'b1;
                r_dst_ptr <= r_dst_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
